// File: rtl/apb_bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb_bus_pkg
//  Description : Shared types and default widths for the APB master bridge.
//  Revision    : 1.0 - initial release
// ============================================================================
package apb_bus_pkg;

    // Default bridge geometry
    localparam int c_DEF_DATA_WIDTH    = 32;
    localparam int c_DEF_ADDRESS_WIDTH = 4;
    localparam int c_DEF_STRB_WIDTH    = c_DEF_DATA_WIDTH / 8;
    localparam int c_DEF_SLAVES_NUM    = 2;

    // Protocol phase encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_t;

endpackage : apb_bus_pkg
`default_nettype wire

// File: rtl/apb_bus_addr_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : apb_addr_decoder
//  Description : Turns the slave index field of the address into a one-hot
//                PSEL vector; all-zero when the bus is not selecting.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_addr_decoder #(
    parameter int SLAVES_NUM = 2,
    parameter int IDX_WIDTH  = $clog2(SLAVES_NUM)
) (
    input  logic                  i_enable,
    input  logic [IDX_WIDTH-1:0]  i_index,
    output logic [SLAVES_NUM-1:0] o_sel
);

    // One comparator per slave line
    generate
        for (genvar gi = 0; gi < SLAVES_NUM; gi++) begin : g_sel
            assign o_sel[gi] = i_enable && (i_index == IDX_WIDTH'(gi));
        end
    endgenerate

endmodule : apb_addr_decoder
`default_nettype wire

// File: rtl/apb_bus.sv
`default_nettype none
// ============================================================================
//  Module      : apb_bus
//  Description : APB4-style master bridge. Runs IDLE/SETUP/ACCESS, decodes the
//                request address into a one-hot PSEL and returns read data and
//                slave error of the last completed transfer.
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_bus
    import apb_bus_pkg::*;
#(
    parameter int DATA_WIDTH    = c_DEF_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = c_DEF_ADDRESS_WIDTH,
    parameter int STRB_WIDTH    = c_DEF_STRB_WIDTH,
    parameter int SLAVES_NUM    = c_DEF_SLAVES_NUM
) (
    input  logic                     PCLK,
    input  logic                     PRESET,
    input  logic                     Transfer,
    input  logic                     IN_WRITE,
    input  logic [ADDRESS_WIDTH-1:0] IN_ADDR,
    input  logic [DATA_WIDTH-1:0]    IN_DATA,
    input  logic [STRB_WIDTH-1:0]    IN_STRB,
    input  logic [DATA_WIDTH-1:0]    PRDATA,
    input  logic                     PREADY,
    input  logic                     PSLVERR,
    output logic [SLAVES_NUM-1:0]    PSEL,
    output logic                     PENABLE,
    output logic                     PWRITE,
    output logic [ADDRESS_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0]    PWDATA,
    output logic [STRB_WIDTH-1:0]    PSTRB,
    output logic [DATA_WIDTH-1:0]    OUT_RDATA,
    output logic                     OUT_SLVERR
);

    localparam int c_IDX_WIDTH = $clog2(SLAVES_NUM);

    apb_state_t                r_state;
    apb_state_t                w_state_nxt;
    logic [ADDRESS_WIDTH-1:0]  r_addr;
    logic [DATA_WIDTH-1:0]     r_wdata;
    logic                      r_write;
    logic [STRB_WIDTH-1:0]     r_strb;
    logic [DATA_WIDTH-1:0]     r_rdata;
    logic                      r_slverr;

    logic                      w_access;
    logic                      w_complete;
    logic                      w_selecting;
    logic [ADDRESS_WIDTH-1:0]  w_paddr;
    logic [DATA_WIDTH-1:0]     w_pwdata;
    logic                      w_pwrite;
    logic [STRB_WIDTH-1:0]     w_pstrb;

    assign w_access    = (r_state == ST_ACCESS);
    assign w_complete  = w_access && PREADY;
    assign w_selecting = (r_state != ST_IDLE);

    // Phase register
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next phase: SETUP always lasts one cycle, ACCESS waits for PREADY
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (Transfer) w_state_nxt = ST_SETUP;
            ST_SETUP:  w_state_nxt = ST_ACCESS;
            ST_ACCESS: if (PREADY) w_state_nxt = Transfer ? ST_SETUP : ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Track the request while not in ACCESS so the bus freezes on entry
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_write <= 1'b0;
            r_strb  <= '0;
        end else if (!w_access) begin
            r_addr  <= IN_ADDR;
            r_wdata <= IN_DATA;
            r_write <= IN_WRITE;
            r_strb  <= IN_WRITE ? IN_STRB : '0;
        end
    end

    // Capture response on the completing edge; writes keep the old read data
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_rdata  <= '0;
            r_slverr <= 1'b0;
        end else if (w_complete) begin
            r_slverr <= PSLVERR;
            if (!r_write) begin
                r_rdata <= PRDATA;
            end
        end
    end

    // Bus fields: live request outside ACCESS, held copy during ACCESS
    always_comb begin
        w_paddr  = IN_ADDR;
        w_pwdata = IN_DATA;
        w_pwrite = IN_WRITE;
        w_pstrb  = IN_WRITE ? IN_STRB : '0;
        if (w_access) begin
            w_paddr  = r_addr;
            w_pwdata = r_wdata;
            w_pwrite = r_write;
            w_pstrb  = r_strb;
        end
    end

    apb_addr_decoder #(
        .SLAVES_NUM (SLAVES_NUM),
        .IDX_WIDTH  (c_IDX_WIDTH)
    ) u_decoder (
        .i_enable (w_selecting),
        .i_index  (w_paddr[ADDRESS_WIDTH-1 -: c_IDX_WIDTH]),
        .o_sel    (PSEL)
    );

    assign PENABLE    = w_access;
    assign PADDR      = w_paddr;
    assign PWDATA     = w_pwdata;
    assign PWRITE     = w_pwrite;
    assign PSTRB      = w_pstrb;
    assign OUT_RDATA  = r_rdata;
    assign OUT_SLVERR = r_slverr;

endmodule : apb_bus
`default_nettype wire

// File: tb/tb_apb_bus.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_bus
//  Description : Self-checking bench for apb_bus: per-cycle vector table with a
//                completion scoreboard, plus reset and long-wait sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_bus;

    logic        clk;
    logic        rst;
    logic        transfer;
    logic        in_write;
    logic [3:0]  in_addr;
    logic [31:0] in_data;
    logic [3:0]  in_strb;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
    logic [1:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [3:0]  paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [31:0] out_rdata;
    logic        out_slverr;

    apb_bus dut (
        .PCLK       (clk),
        .PRESET     (rst),
        .Transfer   (transfer),
        .IN_WRITE   (in_write),
        .IN_ADDR    (in_addr),
        .IN_DATA    (in_data),
        .IN_STRB    (in_strb),
        .PRDATA     (prdata),
        .PREADY     (pready),
        .PSLVERR    (pslverr),
        .PSEL       (psel),
        .PENABLE    (penable),
        .PWRITE     (pwrite),
        .PADDR      (paddr),
        .PWDATA     (pwdata),
        .PSTRB      (pstrb),
        .OUT_RDATA  (out_rdata),
        .OUT_SLVERR (out_slverr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus and the bus outputs expected during that cycle
    typedef struct {
        logic        tr;
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] prd;
        logic        rdy;
        logic        err;
        logic        chk_bus;
        logic [1:0]  e_sel;
        logic        e_en;
        logic [3:0]  e_paddr;
        logic [31:0] e_pwdata;
        logic        e_pwrite;
        logic [3:0]  e_pstrb;
    } vec_t;

    vec_t        vecs[$];
    logic [32:0] sb_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_rdata  = '0;
    logic        exp_slverr = 1'b0;
    logic [31:0] pred_rdata = '0;

    function automatic vec_t v(logic tr, logic wr, logic [3:0] addr, logic [31:0] data,
                               logic [3:0] strb, logic [31:0] prd, logic rdy, logic err,
                               logic [1:0] sel, logic en, logic [3:0] pa, logic [31:0] pw,
                               logic pwr, logic [3:0] ps);
        vec_t r;
        r.tr = tr; r.wr = wr; r.addr = addr; r.data = data; r.strb = strb;
        r.prd = prd; r.rdy = rdy; r.err = err; r.chk_bus = 1'b1;
        r.e_sel = sel; r.e_en = en; r.e_paddr = pa; r.e_pwdata = pw;
        r.e_pwrite = pwr; r.e_pstrb = ps;
        return r;
    endfunction

    // IDLE cycle: only select/enable are checked
    function automatic vec_t vi(logic tr, logic wr, logic [3:0] addr, logic [31:0] data,
                                logic [3:0] strb);
        vec_t r;
        r = v(tr, wr, addr, data, strb, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0, 4'h0, 32'h0, 1'b0, 4'h0);
        r.chk_bus = 1'b0;
        return r;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t r);
        transfer = r.tr; in_write = r.wr; in_addr = r.addr; in_data = r.data;
        in_strb = r.strb; prdata = r.prd; pready = r.rdy; pslverr = r.err;
    endtask

    // Pop any completion from the previous edge, then check the held results
    task automatic check_results(input int idx);
        logic [32:0] e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            exp_rdata  = e[32:1];
            exp_slverr = e[0];
        end
        chk("out_rdata", idx, out_rdata, exp_rdata);
        chk("out_slverr", idx, {31'b0, out_slverr}, {31'b0, exp_slverr});
    endtask

    task automatic run_vec(input vec_t r, input int idx);
        drive(r);
        @(negedge clk);
        check_results(idx);
        chk("psel", idx, {30'b0, psel}, {30'b0, r.e_sel});
        chk("penable", idx, {31'b0, penable}, {31'b0, r.e_en});
        if (r.chk_bus) begin
            chk("paddr", idx, {28'b0, paddr}, {28'b0, r.e_paddr});
            chk("pwdata", idx, pwdata, r.e_pwdata);
            chk("pwrite", idx, {31'b0, pwrite}, {31'b0, r.e_pwrite});
            chk("pstrb", idx, {28'b0, pstrb}, {28'b0, r.e_pstrb});
        end
        if (r.e_en && r.rdy) begin
            if (!r.e_pwrite) pred_rdata = r.prd;
            sb_q.push_back({pred_rdata, r.err});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Write, no wait states, back-to-back then drop Transfer
        vecs.push_back(vi(1, 1, 4'hF, 240, 4'hF));
        vecs.push_back(v(1, 1, 4'hF, 240, 4'hF, 0, 0, 0, 2'b10, 0, 4'hF, 240, 1, 4'hF));
        vecs.push_back(v(1, 1, 4'h1, 15,  4'h3, 0, 1, 0, 2'b10, 1, 4'hF, 240, 1, 4'hF));
        vecs.push_back(v(0, 1, 4'h1, 15,  4'h3, 0, 0, 0, 2'b01, 0, 4'h1, 15,  1, 4'h3));
        vecs.push_back(v(0, 1, 4'h1, 99,  4'h3, 0, 1, 0, 2'b01, 1, 4'h1, 15,  1, 4'h3));
        vecs.push_back(vi(0, 0, 4'h0, 0, 4'h0));
        // Write with 3 wait states each; request inputs wander during waits
        vecs.push_back(vi(1, 1, 4'hF, 240, 4'hF));
        vecs.push_back(v(1, 1, 4'hF, 240, 4'hF, 0, 0, 0, 2'b10, 0, 4'hF, 240, 1, 4'hF));
        for (int i = 0; i < 3; i++)
            vecs.push_back(v(1, 1, 4'h2, 7, 4'h1, 0, 0, 1, 2'b10, 1, 4'hF, 240, 1, 4'hF));
        vecs.push_back(v(1, 1, 4'h1, 15, 4'h3, 0, 1, 0, 2'b10, 1, 4'hF, 240, 1, 4'hF));
        vecs.push_back(v(1, 1, 4'h1, 15, 4'h3, 0, 0, 0, 2'b01, 0, 4'h1, 15,  1, 4'h3));
        for (int i = 0; i < 3; i++)
            vecs.push_back(v(0, 1, 4'h1, 15, 4'h3, 0, 0, 0, 2'b01, 1, 4'h1, 15, 1, 4'h3));
        vecs.push_back(v(0, 1, 4'h1, 15, 4'h3, 0, 1, 0, 2'b01, 1, 4'h1, 15, 1, 4'h3));
        vecs.push_back(vi(0, 0, 4'h0, 0, 4'h0));
        // Read, no wait states
        vecs.push_back(vi(1, 0, 4'hF, 0, 4'hF));
        vecs.push_back(v(1, 0, 4'hF, 0, 4'hF, 0,   0, 0, 2'b10, 0, 4'hF, 0, 0, 4'h0));
        vecs.push_back(v(1, 0, 4'h1, 0, 4'hF, 240, 1, 0, 2'b10, 1, 4'hF, 0, 0, 4'h0));
        vecs.push_back(v(0, 0, 4'h1, 0, 4'hF, 0,   0, 0, 2'b01, 0, 4'h1, 0, 0, 4'h0));
        vecs.push_back(v(0, 0, 4'h1, 0, 4'hF, 15,  1, 0, 2'b01, 1, 4'h1, 0, 0, 4'h0));
        vecs.push_back(vi(0, 0, 4'h0, 0, 4'h0));
        // Read with 3 wait states; junk PRDATA while not ready
        vecs.push_back(vi(1, 0, 4'hF, 0, 4'hF));
        vecs.push_back(v(1, 0, 4'hF, 0, 4'hF, 0, 0, 0, 2'b10, 0, 4'hF, 0, 0, 4'h0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(v(1, 0, 4'hF, 0, 4'hF, 32'hDEAD, 0, 0, 2'b10, 1, 4'hF, 0, 0, 4'h0));
        vecs.push_back(v(1, 0, 4'h1, 0, 4'hF, 240, 1, 0, 2'b10, 1, 4'hF, 0, 0, 4'h0));
        vecs.push_back(v(1, 0, 4'h1, 0, 4'hF, 0,   0, 0, 2'b01, 0, 4'h1, 0, 0, 4'h0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(v(0, 0, 4'h1, 0, 4'hF, 32'hBEEF, 0, 0, 2'b01, 1, 4'h1, 0, 0, 4'h0));
        vecs.push_back(v(0, 0, 4'h1, 0, 4'hF, 15, 1, 0, 2'b01, 1, 4'h1, 0, 0, 4'h0));
        vecs.push_back(vi(0, 0, 4'h0, 0, 4'h0));
        // Slave error on a write; READY/ERR in SETUP ignored; clean read clears it
        vecs.push_back(vi(1, 1, 4'h8, 32'hA5, 4'h1));
        vecs.push_back(v(1, 1, 4'h8, 32'hA5, 4'h1, 32'hBAD, 1, 1, 2'b10, 0, 4'h8, 32'hA5, 1, 4'h1));
        vecs.push_back(v(1, 0, 4'h0, 0, 4'hF, 0, 1, 1, 2'b10, 1, 4'h8, 32'hA5, 1, 4'h1));
        vecs.push_back(v(0, 0, 4'h0, 0, 4'hF, 32'hBAD, 1, 1, 2'b01, 0, 4'h0, 0, 0, 4'h0));
        vecs.push_back(v(0, 0, 4'h0, 0, 4'hF, 77, 1, 0, 2'b01, 1, 4'h0, 0, 0, 4'h0));
        vecs.push_back(vi(0, 0, 4'h0, 0, 4'h0));

        // Reset held two cycles with quiet inputs
        rst = 1'b1;
        drive(vi(0, 0, 4'h0, 0, 4'h0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_psel", 0, {30'b0, psel}, 32'h0);
        chk("rst_penable", 0, {31'b0, penable}, 32'h0);
        chk("rst_pwrite", 0, {31'b0, pwrite}, 32'h0);
        chk("rst_paddr", 0, {28'b0, paddr}, 32'h0);
        chk("rst_pwdata", 0, pwdata, 32'h0);
        chk("rst_pstrb", 0, {28'b0, pstrb}, 32'h0);
        chk("rst_rdata", 0, out_rdata, 32'h0);
        chk("rst_slverr", 0, {31'b0, out_slverr}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);
        drive(vi(0, 0, 4'h0, 0, 4'h0));
        @(negedge clk);
        check_results(vecs.size());

        // Long ACCESS without PREADY, then reset aborts the completing edge
        @(posedge clk); #1;
        drive(vi(1, 0, 4'hF, 0, 4'hF));
        @(posedge clk); #1;
        @(posedge clk); #1;
        pready = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("long_wait_penable", 100, {31'b0, penable}, 32'h1);
        chk("long_wait_psel", 100, {30'b0, psel}, 32'h2);
        @(posedge clk); #1;
        pready = 1'b1; prdata = 32'h55; pslverr = 1'b1; transfer = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        drive(vi(0, 0, 4'h0, 0, 4'h0));
        rst = 1'b0;
        @(negedge clk);
        chk("abort_psel", 101, {30'b0, psel}, 32'h0);
        chk("abort_penable", 101, {31'b0, penable}, 32'h0);
        chk("abort_rdata", 101, out_rdata, 32'h0);
        chk("abort_slverr", 101, {31'b0, out_slverr}, 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("idle_stays_psel", 102, {30'b0, psel}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_apb_bus
`default_nettype wire
